// File: rtl/mem_access_if.sv
// Request/memory-side bus of the MEM-stage load/store unit.
// The slave modport is the unit itself; the master modport is the EX/MEM stage plus the data memory.
interface mem_access_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  i_memread;
  logic                  i_memwrite;
  logic [1:0]            i_size;
  logic                  i_unsigned;
  logic [DATA_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_datawrite;
  logic [DATA_WIDTH-1:0] i_mem_dataread;
  logic [DATA_WIDTH-1:0] o_mem_address;
  logic [DATA_WIDTH-1:0] o_mem_datawrite;
  logic                  o_mem_memread;
  logic                  o_mem_memwrite;
  logic                  o_stall;
  logic [DATA_WIDTH-1:0] o_load_data;
  logic                  o_load_valid;
  logic                  o_misaligned;

  modport slave (
    input  i_valid, i_memread, i_memwrite, i_size, i_unsigned, i_address, i_datawrite,
           i_mem_dataread,
    output o_mem_address, o_mem_datawrite, o_mem_memread, o_mem_memwrite, o_stall,
           o_load_data, o_load_valid, o_misaligned
  );

  modport master (
    output i_valid, i_memread, i_memwrite, i_size, i_unsigned, i_address, i_datawrite,
           i_mem_dataread,
    input  o_mem_address, o_mem_datawrite, o_mem_memread, o_mem_memwrite, o_stall,
           o_load_data, o_load_valid, o_misaligned
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word-indexed memory access, read-modify-write for
// sub-word stores, load lane extraction/extension and misalignment flagging.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           i_clock,
  input  logic           i_reset,
  mem_access_if.slave    bus,
  output logic [0:0]     o_dbg_state
);
  // Handshake: i_valid qualifies a request in any IDLE cycle; while o_stall=1 the
  // requester holds the same request and it is consumed at the end of the RMW.
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] RMW_WRITE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] old_word_q, old_word_d;
  logic [29:0]           idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [15:0]           data_q, data_d;
  logic                  half_q, half_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  misaligned_q, misaligned_d;

  logic                  is_half, is_word, misal, req, store_ok, load_ok;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_ext, merged;

  assign is_half  = (bus.i_size == 2'b01);
  assign is_word  = bus.i_size[1];
  assign misal    = (is_half && bus.i_address[0]) || (is_word && (bus.i_address[1:0] != 2'b00));
  assign req      = bus.i_valid && (bus.i_memread || bus.i_memwrite);
  assign store_ok = bus.i_valid && bus.i_memwrite && !misal;
  assign load_ok  = bus.i_valid && bus.i_memread && !bus.i_memwrite && !misal;

  assign lane_byte = bus.i_mem_dataread[{bus.i_address[1:0], 3'b000} +: 8];
  assign lane_half = bus.i_mem_dataread[{bus.i_address[1], 4'b0000} +: 16];

  always_comb begin
    case (bus.i_size)
      2'b00:   load_ext = bus.i_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = bus.i_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_ext = bus.i_mem_dataread;
    endcase
  end

  always_comb begin
    merged = old_word_q;
    if (half_q) merged[{lane_q[1], 4'b0000} +: 16] = data_q;
    else        merged[{lane_q, 3'b000} +: 8]      = data_q[7:0];
  end

  // Strobes are forced low during reset so a pending RMW write is dropped.
  always_comb begin
    bus.o_mem_address   = {2'b00, bus.i_address[31:2]};
    bus.o_mem_datawrite = bus.i_datawrite;
    bus.o_mem_memread   = 1'b0;
    bus.o_mem_memwrite  = 1'b0;
    bus.o_stall         = 1'b0;
    if (!i_reset) begin
      if (state_q == RMW_WRITE) begin
        bus.o_mem_address   = {2'b00, idx_q};
        bus.o_mem_datawrite = merged;
        bus.o_mem_memwrite  = 1'b1;
      end else if (store_ok) begin
        if (is_word) begin
          bus.o_mem_memwrite = 1'b1;
        end else begin
          bus.o_mem_memread = 1'b1;
          bus.o_stall       = 1'b1;
        end
      end else if (load_ok) begin
        bus.o_mem_memread = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    old_word_d   = old_word_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    data_d       = data_q;
    half_d       = half_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    if (state_q == RMW_WRITE) begin
      state_d = IDLE;
    end else if (req && misal) begin
      misaligned_d = 1'b1;
    end else if (load_ok) begin
      load_data_d  = load_ext;
      load_valid_d = 1'b1;
    end else if (store_ok && !is_word) begin
      old_word_d = bus.i_mem_dataread;
      idx_d      = bus.i_address[31:2];
      lane_d     = bus.i_address[1:0];
      data_d     = bus.i_datawrite[15:0];
      half_d     = is_half;
      state_d    = RMW_WRITE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      old_word_q   <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
      data_q       <= '0;
      half_q       <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      old_word_q   <= old_word_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      data_q       <= data_d;
      half_q       <= half_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.o_load_data  = load_data_q;
  assign bus.o_load_valid = load_valid_q;
  assign bus.o_misaligned = misaligned_q;
  assign o_dbg_state      = state_q;
endmodule
